// File: rtl/nem_ohmux_sel_ctrl_pkg.sv
// Shared types and helpers for the NEM-relay one-hot mux select sequencer.
package nem_sel_pkg;

    localparam int unsigned MAX_N         = 16;
    localparam int unsigned DEF_BREAK_CYC = 4;
    localparam int unsigned DEF_MAKE_CYC  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        MAKE  = 2'd2,
        HOLD  = 2'd3
    } sel_state_e;

    // Out-of-range index yields all-zero so callers can treat it as "open"
    function automatic logic [MAX_N-1:0] onehot(input logic [3:0] idx, input int unsigned n);
        logic [MAX_N-1:0] v;
        v = '0;
        if (32'(idx) < n) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nem_ohmux_sel_ctrl_if.sv
// Request and select-line bundle between a relay-bank client and nem_ohmux_sel_ctrl.
interface nem_ohmux_sel_ctrl_if #(
    parameter int unsigned N_IN = 2
);
    localparam int unsigned IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic             req_valid;
    logic             req_ready;
    logic             req_off;
    logic [IDX_W-1:0] req_idx;
    logic [N_IN-1:0]  sel;
    logic             settled;
    logic             busy;

    modport master (
        output req_valid, req_off, req_idx,
        input  req_ready, sel, settled, busy
    );

    modport slave (
        input  req_valid, req_off, req_idx,
        output req_ready, sel, settled, busy
    );

endinterface

// File: rtl/nem_ohmux_sel_ctrl_timer.sv
// Loadable down-counter for relay sequencing; done reads high while the count is 1.
module nem_sel_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign done = (count_q == W'(1));

endmodule

// File: rtl/nem_ohmux_sel_ctrl.sv
// Break-before-make one-hot select driver for NEM-relay mux banks.
// Optional NEM_SEL_ERR_EN adds a sticky err output for out-of-range req_idx.
module nem_ohmux_sel_ctrl
    import nem_sel_pkg::*;
#(
    parameter int unsigned N_IN      = 2,
    parameter int unsigned BREAK_CYC = DEF_BREAK_CYC,
    parameter int unsigned MAKE_CYC  = DEF_MAKE_CYC
) (
    input  logic               clk,
    input  logic               rst,
    nem_ohmux_sel_ctrl_if.slave bus
`ifdef NEM_SEL_ERR_EN
    ,
    output logic               err
`endif
);

    localparam int unsigned IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned TW    = $clog2(max_u(BREAK_CYC, MAKE_CYC) + 1);
    localparam logic [TW-1:0] BREAK_LD = TW'(BREAK_CYC);
    localparam logic [TW-1:0] MAKE_LD  = TW'(MAKE_CYC);

    sel_state_e      state_q, state_d;
    logic [N_IN-1:0] sel_q, sel_d;
    logic [N_IN-1:0] tgt_q, tgt_d;
    logic [N_IN-1:0] req_oh;
    logic            accept;
    logic            idx_ok;
    logic            req_is_off;
    logic            t_load;
    logic [TW-1:0]   t_val;
    logic            t_done;

    assign accept     = bus.req_valid & bus.req_ready;
    assign idx_ok     = ({1'b0, bus.req_idx} < (IDX_W + 1)'(N_IN));
    assign req_is_off = bus.req_off | ~idx_ok;
    assign req_oh     = req_is_off ? '0 : N_IN'(onehot(4'(bus.req_idx), N_IN));

    nem_sel_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    // tgt_q carries the pending selection across BREAK; zero means finish in IDLE
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tgt_d   = tgt_q;
        t_load  = 1'b0;
        t_val   = '0;
        unique case (state_q)
            IDLE: begin
                if (accept && !req_is_off) begin
                    state_d = MAKE;
                    sel_d   = req_oh;
                    t_load  = 1'b1;
                    t_val   = MAKE_LD;
                end
            end
            HOLD: begin
                if (accept && (req_oh != sel_q)) begin
                    state_d = BREAK;
                    sel_d   = '0;
                    tgt_d   = req_oh;
                    t_load  = 1'b1;
                    t_val   = BREAK_LD;
                end
            end
            BREAK: begin
                if (t_done) begin
                    if (tgt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = MAKE;
                        sel_d   = tgt_q;
                        t_load  = 1'b1;
                        t_val   = MAKE_LD;
                    end
                end
            end
            MAKE: begin
                if (t_done) begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tgt_q   <= tgt_d;
        end
    end

`ifdef NEM_SEL_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept && !bus.req_off && !idx_ok) begin
            err <= 1'b1;
        end
    end
`endif

    assign bus.sel       = sel_q;
    assign bus.settled   = (state_q == HOLD);
    assign bus.busy      = (state_q == BREAK) || (state_q == MAKE);
    assign bus.req_ready = (state_q == IDLE) || (state_q == HOLD);

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// Self-checking bench for nem_ohmux_sel_ctrl: directed vector table, err corner cases,
// and a randomized run against a timeline-queue model of the select sequencing.
module tb_nem_ohmux_sel_ctrl;

`ifdef NEM_SEL_ERR_EN
    localparam int unsigned N = 3;
`else
    localparam int unsigned N = 2;
`endif
    localparam int unsigned B     = 4;
    localparam int unsigned M     = 8;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef NEM_SEL_ERR_EN
    logic err;
`endif

    always #5 clk = ~clk;

    nem_ohmux_sel_ctrl_if #(.N_IN(N)) bus ();

    nem_ohmux_sel_ctrl #(
        .N_IN      (N),
        .BREAK_CYC (B),
        .MAKE_CYC  (M)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef NEM_SEL_ERR_EN
        ,
        .err (err)
`endif
    );

    typedef struct {
        logic [N-1:0] sel;
        logic         settled;
        logic         busy;
        logic         ready;
    } out_t;

    typedef struct {
        string        name;
        logic         r;
        logic         v;
        logic         off;
        int unsigned  idx;
        int unsigned  n;
        logic [N-1:0] sel;
        logic         settled;
        logic         busy;
        logic         ready;
    } vec_t;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model: queue of outputs for the cycles still to come in a transition,
    // plus the connection that remains once the queue drains.
    out_t         q[$];
    logic [N-1:0] steady;
    logic         m_err;

    function automatic out_t cur_exp();
        out_t o;
        if (q.size() != 0) begin
            o = q[0];
        end else begin
            o.sel     = steady;
            o.settled = (steady != '0);
            o.busy    = 1'b0;
            o.ready   = 1'b1;
        end
        return o;
    endfunction

    task automatic push_n(input logic [N-1:0] s, input int unsigned n);
        out_t o;
        o.sel     = s;
        o.settled = 1'b0;
        o.busy    = 1'b1;
        o.ready   = 1'b0;
        for (int unsigned i = 0; i < n; i++) q.push_back(o);
    endtask

    task automatic model_edge(input logic r, input logic v, input logic off, input int unsigned idx);
        out_t         c;
        logic         acc;
        logic [N-1:0] oh;
        c   = cur_exp();
        acc = v & c.ready;
        if (r) begin
            q.delete();
            steady = '0;
            m_err  = 1'b0;
        end else begin
            if (q.size() != 0) void'(q.pop_front());
            if (acc) begin
                oh = (off || idx >= N) ? '0 : N'(1 << idx);
                if (!off && idx >= N) m_err = 1'b1;
                if (steady == '0) begin
                    if (oh != '0) push_n(oh, M);
                    steady = oh;
                end else if (oh != steady) begin
                    push_n('0, B);
                    if (oh != '0) push_n(oh, M);
                    steady = oh;
                end
            end
        end
    endtask

    task automatic drive_edge(input logic r, input logic v, input logic off, input int unsigned idx);
        rst           = r;
        bus.req_valid = v;
        bus.req_off   = off;
        bus.req_idx   = IDX_W'(idx);
        model_edge(r, v, off, idx);
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input out_t e);
        checks++;
        if (bus.sel !== e.sel || bus.settled !== e.settled || bus.busy !== e.busy ||
            bus.req_ready !== e.ready) begin
            errors++;
            $display("FAIL %s t=%0t got sel=%b settled=%b busy=%b ready=%b want sel=%b settled=%b busy=%b ready=%b",
                     name, $time, bus.sel, bus.settled, bus.busy, bus.req_ready,
                     e.sel, e.settled, e.busy, e.ready);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %b want %b", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic r, input logic v, input logic off,
                                input int unsigned idx, input int unsigned n, input int unsigned sel,
                                input logic settled, input logic busy, input logic ready);
        vec_t t;
        t.name = name; t.r = r; t.v = v; t.off = off; t.idx = idx; t.n = n;
        t.sel = N'(sel); t.settled = settled; t.busy = busy; t.ready = ready;
        return t;
    endfunction

    vec_t tbl[13];

    initial begin
        out_t e;
        logic pend_v;
        logic pend_off;
        int unsigned pend_idx;
        logic r;

        bus.req_valid = 1'b0;
        bus.req_off   = 1'b0;
        bus.req_idx   = '0;
        steady        = '0;
        m_err         = 1'b0;

        tbl[0]  = mk("reset",         1, 0, 0, 0, 1, 0, 0, 0, 1);
        tbl[1]  = mk("idle_make",     0, 1, 0, 1, 8, 2, 0, 1, 0);
        tbl[2]  = mk("idle_settled",  0, 0, 0, 0, 2, 2, 1, 0, 1);
        tbl[3]  = mk("swap_break",    0, 1, 0, 0, 4, 0, 0, 1, 0);
        tbl[4]  = mk("swap_make",     0, 0, 0, 0, 8, 1, 0, 1, 0);
        tbl[5]  = mk("swap_settled",  0, 0, 0, 0, 1, 1, 1, 0, 1);
        tbl[6]  = mk("same_noop",     0, 1, 0, 0, 3, 1, 1, 0, 1);
        tbl[7]  = mk("off_break",     0, 1, 1, 0, 4, 0, 0, 1, 0);
        tbl[8]  = mk("off_idle",      0, 0, 0, 0, 2, 0, 0, 0, 1);
        tbl[9]  = mk("off_in_idle",   0, 1, 1, 1, 2, 0, 0, 0, 1);
        tbl[10] = mk("make_pre_rst",  0, 1, 0, 0, 3, 1, 0, 1, 0);
        tbl[11] = mk("rst_mid_make",  1, 0, 0, 0, 1, 0, 0, 0, 1);
        tbl[12] = mk("post_rst_idle", 0, 0, 0, 0, 2, 0, 0, 0, 1);

        for (int i = 0; i < 13; i++) begin
            for (int unsigned k = 0; k < tbl[i].n; k++) begin
                if (k == 0) drive_edge(tbl[i].r, tbl[i].v, tbl[i].off, tbl[i].idx);
                else        drive_edge(1'b0, 1'b0, 1'b0, 0);
                e.sel     = tbl[i].sel;
                e.settled = tbl[i].settled;
                e.busy    = tbl[i].busy;
                e.ready   = tbl[i].ready;
                check_out(tbl[i].name, e);
            end
        end

`ifdef NEM_SEL_ERR_EN
        drive_edge(1'b1, 1'b0, 1'b0, 0);
        check_bit("err_reset", err, 1'b0);
        drive_edge(1'b0, 1'b1, 1'b0, 3);
        check_bit("err_set", err, 1'b1);
        check_bit("err_sel_zero", (bus.sel == '0), 1'b1);
        check_bit("err_idle_ready", bus.req_ready, 1'b1);
        drive_edge(1'b0, 1'b1, 1'b0, 1);
        for (int i = 0; i < 10; i++) drive_edge(1'b0, 1'b0, 1'b0, 0);
        check_bit("err_sticky", err, 1'b1);
        check_bit("err_legal_sel", (bus.sel == N'(2)), 1'b1);
        drive_edge(1'b1, 1'b0, 1'b0, 0);
        check_bit("err_cleared", err, 1'b0);
`endif

        drive_edge(1'b1, 1'b0, 1'b0, 0);
        check_out("rand_reset", cur_exp());
        pend_v   = 1'b0;
        pend_off = 1'b0;
        pend_idx = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            r = ($urandom_range(0, 499) == 0);
            if (!pend_v && ($urandom_range(0, 2) == 0)) begin
                pend_v   = 1'b1;
                pend_off = ($urandom_range(0, 5) == 0);
                pend_idx = $urandom_range(0, (1 << IDX_W) - 1);
            end
            e = cur_exp();
            drive_edge(r, pend_v, pend_off, pend_idx);
            if (r || e.ready) pend_v = 1'b0;
            check_out("rand", cur_exp());
`ifdef NEM_SEL_ERR_EN
            check_bit("rand_err", err, m_err);
`endif
            checks++;
            if ($countones(bus.sel) > 1) begin
                errors++;
                $display("FAIL onehot t=%0t got sel=%b want at most one bit set", $time, bus.sel);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
